// File: rtl/mmio_pkg.sv
// Shared register map and bit positions for the memory-mapped timer.
package mmio_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0900;

   localparam logic [5:0] OFF_CTRL   = 6'h00;
   localparam logic [5:0] OFF_LOAD   = 6'h04;
   localparam logic [5:0] OFF_COUNT  = 6'h08;
   localparam logic [5:0] OFF_STATUS = 6'h0C;
   localparam logic [5:0] OFF_CYCLES = 6'h10;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IE     = 2;
   localparam int STATUS_PEND = 0;

   // Word-aligned byte offset inside the 64-byte register window.
   function automatic logic [5:0] word_off(input logic [3:0] word_idx);
      return {word_idx, 2'b00};
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while enabled; tick marks the last cycle of each period.
module timer_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_r;

   assign tick = en & (cnt_r == LAST);

   // Prescale counter: clear has priority, freezes while disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {PW{1'b0}};
      end else if (clr) begin
         cnt_r <= {PW{1'b0}};
      end else if (en) begin
         if (cnt_r == LAST) begin
            cnt_r <= {PW{1'b0}};
         end else begin
            cnt_r <= cnt_r + PW'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/mmio_timer_irq.sv
// Memory-mapped down-counter timer with level interrupt on expiry.
// Optional free-running CYCLES register at 0x10 when TIMER_CYCLE_CNT_EN is defined.
module mmio_timer_irq
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          PRESCALE  = 4,
   parameter int          CNT_W     = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic        sel,
   output logic [31:0] rd,
   output logic        irq
);

   logic [2:0]       ctrl_r, ctrl_nxt_s;
   logic [CNT_W-1:0] load_r, load_nxt_s;
   logic [CNT_W-1:0] count_r, count_nxt_s;
   logic             pend_r, pend_nxt_s;
   logic             irq_r;
   logic [5:0]       off_s;
   logic             wr_s, tick_s, expire_s, presc_clr_s;
   logic             unused_s;

   assign sel         = (addr[31:6] == BASE_ADDR[31:6]);
   assign off_s       = word_off(addr[5:2]);
   assign unused_s    = ^addr[1:0];
   assign wr_s        = we & sel;
   assign expire_s    = tick_s & (count_r == {CNT_W{1'b0}});
   assign presc_clr_s = wr_s & (off_s == OFF_CTRL) & ~ctrl_r[CTRL_EN] & wd[CTRL_EN];
   assign irq         = irq_r;

   timer_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (ctrl_r[CTRL_EN]),
      .clr  (presc_clr_s),
      .tick (tick_s)
   );

   // Next-state: timer events first, bus writes then override (PEND set still wins).
   always_comb begin
      ctrl_nxt_s  = ctrl_r;
      load_nxt_s  = load_r;
      count_nxt_s = count_r;
      pend_nxt_s  = pend_r;
      if (tick_s) begin
         if (count_r != {CNT_W{1'b0}}) begin
            count_nxt_s = count_r - CNT_W'(1);
         end else begin
            pend_nxt_s = 1'b1;
            if (ctrl_r[CTRL_AUTO]) begin
               count_nxt_s = load_r;
            end else begin
               ctrl_nxt_s[CTRL_EN] = 1'b0;
            end
         end
      end else begin
         count_nxt_s = count_r;
      end
      if (wr_s) begin
         case (off_s)
            OFF_CTRL: begin
               ctrl_nxt_s = wd[2:0];
               if (presc_clr_s) begin
                  count_nxt_s = load_r;
               end else begin
                  count_nxt_s = count_nxt_s;
               end
            end
            OFF_LOAD: begin
               load_nxt_s  = wd[CNT_W-1:0];
               count_nxt_s = wd[CNT_W-1:0];
            end
            OFF_STATUS: begin
               if (wd[STATUS_PEND] && !expire_s) begin
                  pend_nxt_s = 1'b0;
               end else begin
                  pend_nxt_s = pend_nxt_s;
               end
            end
            default: begin
               ctrl_nxt_s = ctrl_nxt_s;
            end
         endcase
      end else begin
         ctrl_nxt_s = ctrl_nxt_s;
      end
   end

   // Timer state; irq is registered from next-state so it has no bus-to-pin path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_r  <= 3'b000;
         load_r  <= {CNT_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         pend_r  <= 1'b0;
         irq_r   <= 1'b0;
      end else begin
         ctrl_r  <= ctrl_nxt_s;
         load_r  <= load_nxt_s;
         count_r <= count_nxt_s;
         pend_r  <= pend_nxt_s;
         irq_r   <= pend_nxt_s & ctrl_nxt_s[CTRL_IE];
      end
   end

`ifdef TIMER_CYCLE_CNT_EN
   logic [31:0] cycles_r;

   // Free-running cycle counter, independent of EN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycles_r <= 32'h0000_0000;
      end else begin
         cycles_r <= cycles_r + 32'h0000_0001;
      end
   end
`endif

   // Combinational read mux, zero outside the window.
   always_comb begin
      rd = 32'h0000_0000;
      if (sel) begin
         case (off_s)
            OFF_CTRL:   rd = {29'h0, ctrl_r};
            OFF_LOAD:   rd = 32'(load_r);
            OFF_COUNT:  rd = 32'(count_r);
            OFF_STATUS: rd = {31'h0, pend_r};
`ifdef TIMER_CYCLE_CNT_EN
            OFF_CYCLES: rd = cycles_r;
`else
            OFF_CYCLES: rd = 32'h0000_0000;
`endif
            default:    rd = 32'h0000_0000;
         endcase
      end else begin
         rd = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mmio_timer_irq.sv
// Self-checking bench for mmio_timer_irq: vector tables plus timed corner-case sequences.
module tb_mmio_timer_irq;

   logic        clk, rst, we, sel, irq;
   logic [31:0] addr, wd, rd;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [31:0] addr;
      logic        sel;
      logic [31:0] rd;
      string       name;
   } rv_t;

   typedef struct {
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp;
      string       name;
   } wv_t;

   rv_t rtab[10];
   wv_t wtab[6];

   mmio_timer_irq dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .we   (we),
      .wd   (wd),
      .sel  (sel),
      .rd   (rd),
      .irq  (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic push_exp(input logic [31:0] e, input string n);
      sb_t s;
      s.exp  = e;
      s.name = n;
      sb_q.push_back(s);
   endtask

   task automatic pop_cmp(input logic [31:0] act);
      sb_t s;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: got %h, nothing expected", act);
      end else begin
         s = sb_q.pop_front();
         if (act !== s.exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", s.name, act, s.exp);
         end
      end
   endtask

   task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string n);
      push_exp(e, n);
      addr = a;
      #1;
      pop_cmp(rd);
   endtask

   task automatic sel_chk(input logic [31:0] a, input logic e, input string n);
      push_exp({31'h0, e}, n);
      addr = a;
      #1;
      pop_cmp({31'h0, sel});
   endtask

   task automatic irq_chk(input logic e, input string n);
      push_exp({31'h0, e}, n);
      #1;
      pop_cmp({31'h0, irq});
   endtask

   // Called in the low clock phase; the write lands on the next rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wd   = d;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_cnt;
      n_cmp = 0;
      n_bad = 0;

      rtab[0] = '{32'h0000_0900, 1'b1, 32'h0, "rst_ctrl"};
      rtab[1] = '{32'h0000_0904, 1'b1, 32'h0, "rst_load"};
      rtab[2] = '{32'h0000_0908, 1'b1, 32'h0, "rst_count"};
      rtab[3] = '{32'h0000_090C, 1'b1, 32'h0, "rst_status"};
      rtab[4] = '{32'h0000_0903, 1'b1, 32'h0, "rst_ctrl_bytelane"};
      rtab[5] = '{32'h0000_0920, 1'b1, 32'h0, "rst_reserved"};
      rtab[6] = '{32'h0000_093F, 1'b1, 32'h0, "sel_top_edge"};
      rtab[7] = '{32'h0000_0940, 1'b0, 32'h0, "sel_above"};
      rtab[8] = '{32'h0000_08FC, 1'b0, 32'h0, "sel_below"};
      rtab[9] = '{32'h0001_0900, 1'b0, 32'h0, "sel_alias"};

      wtab[0] = '{32'h0000_0900, 32'h0000_00FA, 32'h0000_0900, 32'h0000_0002, "ctrl_mask"};
      wtab[1] = '{32'h0000_0904, 32'hDEAD_BEEF, 32'h0000_0904, 32'hDEAD_BEEF, "load_rw"};
      wtab[2] = '{32'h0000_0908, 32'h0000_1234, 32'h0000_0908, 32'hDEAD_BEEF, "count_ro"};
      wtab[3] = '{32'h0000_0914, 32'h0000_FFFF, 32'h0000_0914, 32'h0000_0000, "reserved_wr"};
      wtab[4] = '{32'h0000_090C, 32'h0000_0001, 32'h0000_090C, 32'h0000_0000, "status_idle"};
      wtab[5] = '{32'h0000_0940, 32'h0000_0007, 32'h0000_0900, 32'h0000_0002, "outside_ignored"};

      rst  = 1'b0;
      we   = 1'b0;
      addr = 32'h0;
      wd   = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      irq_chk(1'b0, "rst_irq");
      for (int i = 0; i < 10; i++) begin
         sel_chk(rtab[i].addr, rtab[i].sel, {rtab[i].name, "_sel"});
         rd_chk(rtab[i].addr, rtab[i].rd, {rtab[i].name, "_rd"});
      end
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         wr(wtab[i].waddr, wtab[i].wdata);
         rd_chk(wtab[i].raddr, wtab[i].exp, wtab[i].name);
      end

      // One-shot: COUNT 3,2,1,0 at four-clock steps, expiry on the 16th edge.
      wr(32'h0000_0904, 32'd3);
      wr(32'h0000_0900, 32'h5);
      rd_chk(32'h0000_0908, 32'd3, "os_count_start");
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_cnt = (k < 12) ? 32'(3 - k / 4) : 32'd0;
         rd_chk(32'h0000_0908, exp_cnt, $sformatf("os_count_k%0d", k));
         irq_chk((k == 16), $sformatf("os_irq_k%0d", k));
      end
      rd_chk(32'h0000_0900, 32'h4, "os_ctrl_en_cleared");
      rd_chk(32'h0000_090C, 32'h1, "os_pend");

      // Auto-reload: LOAD=2 expires every third tick (12 clocks).
      wr(32'h0000_090C, 32'h1);
      irq_chk(1'b0, "w1c_clears_irq");
      wr(32'h0000_0904, 32'd2);
      wr(32'h0000_0900, 32'h7);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         irq_chk((k == 12), $sformatf("ar_irq_k%0d", k));
      end
      rd_chk(32'h0000_0908, 32'd2, "ar_reloaded");
      wr(32'h0000_090C, 32'h1);
      irq_chk(1'b0, "ar_w1c_k13");
      for (int k = 14; k <= 24; k++) begin
         @(negedge clk);
         irq_chk((k == 24), $sformatf("ar_irq_k%0d", k));
      end

      // W1C on the exact expiry edge (36): set wins.
      wr(32'h0000_090C, 32'h1);
      for (int k = 26; k <= 35; k++) begin
         @(negedge clk);
      end
      irq_chk(1'b0, "sim_pre_irq");
      wr(32'h0000_090C, 32'h1);
      rd_chk(32'h0000_090C, 32'h1, "sim_pend_kept");
      irq_chk(1'b1, "sim_irq_kept");
      wr(32'h0000_0900, 32'h3);
      irq_chk(1'b0, "ie_mask_irq");
      rd_chk(32'h0000_090C, 32'h1, "ie_mask_pend");

      // Async reset between edges while counting with irq asserted.
      wr(32'h0000_0900, 32'h0);
      wr(32'h0000_0904, 32'd5);
      wr(32'h0000_0900, 32'h5);
      rd_chk(32'h0000_0908, 32'd5, "ar5_count");
      irq_chk(1'b1, "ar5_irq");
      #1;
      rst = 1'b0;
      rd_chk(32'h0000_0908, 32'd0, "async_count");
      irq_chk(1'b0, "async_irq");
      rd_chk(32'h0000_0900, 32'd0, "async_ctrl");
      #1;
      rst = 1'b1;
      @(negedge clk);
      rd_chk(32'h0000_090C, 32'd0, "post_rst_status");
      irq_chk(1'b0, "post_rst_irq");

`ifdef TIMER_CYCLE_CNT_EN
      begin
         logic [31:0] c0;
         addr = 32'h0000_0910;
         #1;
         c0 = rd;
         repeat (10) @(negedge clk);
         #1;
         push_exp(c0 + 32'd10, "cycles_delta");
         pop_cmp(rd);
      end
`else
      rd_chk(32'h0000_0910, 32'd0, "cycles_absent");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mmio_timer_irq.md
Name: mmio_timer_irq

Overview:
Memory-mapped down-counter timer that responds on the CPU data-memory bus and raises the CPU `irq` line on expiry.
- Takes the CPU's `alu_out` (address), `we_dm` and `wd_dm`; returns read data on `rd_dm` plus a select flag for the system read mux.
- Sits beside data memory in the full system, as the responder end of the core's load/store and interrupt interface.

Parameters:
- BASE_ADDR, 32'h0000_0900: base of the 16-word-aligned register window; `addr[31:6]` compared to `BASE_ADDR[31:6]`.
- PRESCALE, 4: clock cycles per counter tick, ≥1. A value of 1 gives a tick every cycle.
- CNT_W, 32: counter/load width; registers are zero-extended to 32 bits on read.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from CPU (`alu_out`).
- we  in  1  write strobe from CPU (`we_dm`).
- wd  in  32  write data from CPU (`wd_dm`).
- sel  out  1  address hits this block's window (combinational).
- rd  out  32  read data (combinational; 0 when `sel`=0).
- irq  out  1  interrupt request to CPU, level.

Behaviour:
- Register map, byte offset `addr[5:0]`:
  - 0x00 CTRL, R/W: bit0 EN, bit1 AUTO, bit2 IE.
  - 0x04 LOAD, R/W.
  - 0x08 COUNT, RO.
  - 0x0C STATUS: bit0 PEND, write-1-to-clear.
  - 0x10 CYCLES, RO, optional.
  - All other offsets: read 0, writes ignored.
- `addr[1:0]` is ignored (word access only).
- Reads are combinational in the same cycle as `addr`, matching single-cycle load timing. Writes take effect at the rising clk when `we & sel`.
- Reset (`rst`=0, async): CTRL=0, LOAD=0, COUNT=0, PEND=0, prescaler=0, CYCLES=0. Outputs: `irq`=0, `sel` and `rd` combinational only.
- Write LOAD: LOAD←`wd`, and COUNT←`wd` in the same edge.
- Write CTRL: CTRL←`wd[2:0]`.
  - If EN goes 0→1, COUNT←LOAD and the prescaler clears.
  - EN written to 0 freezes COUNT and the prescaler.
- Prescaler counts 0..PRESCALE-1 while EN=1. `tick` asserts on the cycle it equals PRESCALE-1, then it wraps to 0.
- On tick:
  - COUNT≠0: COUNT←COUNT-1.
  - COUNT==0 (expiry): PEND←1.
    - AUTO=1: COUNT←LOAD.
    - AUTO=0: COUNT stays 0 and EN←0 (one-shot).
- LOAD=0 with AUTO=1 gives expiry every tick.
- `irq` = PEND & IE, registered-state driven with no comb path from the bus.
- Clearing IE masks `irq` but PEND is retained.
- Simultaneous events:
  - Expiry and STATUS W1C in the same edge: PEND stays 1 (set wins).
  - Expiry and write LOAD in the same edge: LOAD/COUNT take the written value, PEND still sets.
  - Expiry and write CTRL: CTRL takes the written value; for a one-shot, the auto-clear of EN applies only if the write did not set EN.
- Reset mid-count aborts immediately to reset values, and `irq` drops asynchronously.

Optional Feature:
- Macro `TIMER_CYCLE_CNT_EN`.
- Defined: 32-bit free-running CYCLES counter, +1 every clk regardless of EN, wraps 0xFFFF_FFFF→0, readable at 0x10, reset to 0.
- Undefined: no counter logic; 0x10 reads 0.

Decomposition:
- Shared package `mmio_pkg`:
  - register offset constants (OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS, OFF_CYCLES);
  - CTRL bit index constants (CTRL_EN, CTRL_AUTO, CTRL_IE), STATUS_PEND;
  - default BASE_ADDR.
- One sub-module, `timer_prescaler`: parameter PRESCALE; inputs clk, rst, en, clr; output tick.

Test Plan:
- Reset: hold `rst`=0 then release → `irq`=0; reads of 0x900/0x904/0x908/0x90C return 0; `sel`=1 for 0x900–0x93F, 0 for 0x940 and 0x8FC.
- One-shot, PRESCALE=4: write LOAD=3, CTRL=0x5 → COUNT steps 3,2,1,0 every 4 clk; PEND=1 and `irq`=1 on the 16th tick edge after enable; CTRL reads 0x4 (EN cleared).
- Auto-reload: LOAD=2, CTRL=0x7 → `irq` rises every 3 ticks. Writing 0x1 to 0x90C clears `irq` for one period, then it reasserts.
- Simultaneous: W1C to STATUS on the exact expiry edge → PEND remains 1. IE=0 with PEND=1 → `irq`=0 while STATUS reads 1.
- Async reset mid-count (COUNT=5, EN=1): `rst` low between edges → COUNT=0 and `irq`=0 immediately without a clock edge.
- With `TIMER_CYCLE_CNT_EN`: read 0x910 twice, 10 cycles apart → difference is 10. Without it → reads 0.
